// File: rtl/sw_debounce_sync_pkg.sv
// Shared definitions for the switch debouncer: per-bit FSM encoding, default sizing
// and the configuration range check used at elaboration.
package sw_debounce_sync_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_DEB_CYCLES = 50000;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

  // Window must be at least one cycle and representable in the counter.
  function automatic bit deb_cfg_ok(input int unsigned deb, input int unsigned cnt_w);
    return (deb >= 32'd1) && ((cnt_w >= 32'd32) || (deb < (32'd1 << cnt_w)));
  endfunction

endpackage

// File: rtl/sw_debounce_sync_bit.sv
// One switch bit: 2-flop synchroniser, STABLE/PENDING debounce FSM and window counter.
module sw_debounce_sync_bit
  import sw_debounce_sync_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sw_in,
  input  logic block,
  output logic upd_c,
  output logic rise_req_c,
  output logic sw_out,
  output logic rise,
  output logic fall,
  output logic pending
);

  logic             s1_q, s2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             differ_c, at_limit_c, accept_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    differ_c   = (s2_q != out_q);
    // A one-cycle window accepts straight from STABLE with no PENDING dwell.
    at_limit_c = (state_q == ST_PENDING) ? (cnt_q >= CNT_W'(DEB_CYCLES - 1))
                                         : (DEB_CYCLES == 1);
    accept_c   = en && differ_c && at_limit_c;
    rise_req_c = accept_c && s2_q;
    upd_c      = accept_c && !(block && s2_q);

    if (!en || !differ_c) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else if (upd_c) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
      out_d   = s2_q;
      rise_d  = s2_q;
      fall_d  = !s2_q;
    end else if (state_q == ST_STABLE) begin
      state_d = ST_PENDING;
      cnt_d   = CNT_W'(1);
    end else if (!accept_c && (cnt_q != '1)) begin
      // A blocked bit parks at the limit so it accepts as soon as it is released.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= sw_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_out  = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign pending = (state_q == ST_PENDING);

endmodule

// File: rtl/sw_debounce_sync.sv
// Synchronised, debounced switch vector with change/edge strobes for the priority encoder.
// Optional SW_DEBOUNCE_LOCK_EN keeps at most one sw_out bit set at any time.
module sw_debounce_sync
  import sw_debounce_sync_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             stable
);

  if (!deb_cfg_ok(DEB_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("sw_debounce_sync: DEB_CYCLES must be in 1..2**CNT_W-1");
  end

  logic [WIDTH-1:0] upd_c, rise_req_c, block_c, pending_c;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_sync_bit #(
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_bit (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sw_in      (sw_in[i]),
      .block      (block_c[i]),
      .upd_c      (upd_c[i]),
      .rise_req_c (rise_req_c[i]),
      .sw_out     (sw_out[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .pending    (pending_c[i])
    );
  end

`ifdef SW_DEBOUNCE_LOCK_EN
  // Hold a rise while any other bit is set, or while a lower bit rises on this edge.
  always_comb begin
    block_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      block_c[i] = |(sw_out & ~(WIDTH'(1) << i));
      for (int j = 0; j < i; j++) begin
        if (rise_req_c[j]) block_c[i] = 1'b1;
      end
    end
  end
`else
  logic unused_rise_req;
  assign unused_rise_req = ^rise_req_c;
  assign block_c         = '0;
`endif

  assign changed_d = |upd_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= changed_d;
  end

  assign changed = changed_q;
  assign stable  = ~|pending_c;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Randomised and directed checks of sw_debounce_sync (WIDTH=8, DEB_CYCLES=4).
module tb_sw_debounce_sync;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEB   = 4;
`ifdef SW_DEBOUNCE_LOCK_EN
  localparam logic [7:0] EXP_ALL = 8'h01;
  localparam logic [7:0] EXP_21  = 8'h01;
`else
  localparam logic [7:0] EXP_ALL = 8'hFF;
  localparam logic [7:0] EXP_21  = 8'h21;
`endif

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] sw_in, sw_out, rise, fall;
  logic       changed, stable;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: output flips once the synchronised input has disagreed for DEB enabled cycles in a row.
  logic [7:0]  m_s1, m_s2, m_out, m_rise, m_fall;
  logic        m_changed, m_stable;
  int unsigned m_run [8];

  always #5 clk = ~clk;

  sw_debounce_sync #(
    .WIDTH      (WIDTH),
    .CNT_W      (16),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .changed (changed),
    .rise    (rise),
    .fall    (fall),
    .stable  (stable)
  );

  task automatic step();
    @(posedge clk);
    m_rise = '0;
    m_fall = '0;
    if (rst) begin
      m_s1  = '0;
      m_s2  = '0;
      m_out = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (en && (m_s2[i] != m_out[i])) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_out[i]  = m_s2[i];
            m_rise[i] = m_s2[i];
            m_fall[i] = ~m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_in;
    end
    m_changed = |(m_rise | m_fall);
    m_stable  = 1'b1;
    for (int i = 0; i < 8; i++) if (m_run[i] != 0) m_stable = 1'b0;
    #1;
  endtask

  task automatic settle(input logic [7:0] v);
    sw_in = v;
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sw_in = 8'hFF;
    #3;
    n_tests++; if (sw_out !== 8'h00) begin n_fail++; $display("FAIL reset_sw_out: got %h want 00", sw_out); end
    n_tests++; if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b want 0", changed); end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL reset_stable: got %b want 1", stable); end
    step(); step();
    n_tests++; if (sw_out !== 8'h00 || rise !== 8'h00) begin n_fail++; $display("FAIL reset_hold: sw_out %h rise %h want 00 00", sw_out, rise); end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e < 6) begin
        n_tests++; if (sw_out !== 8'h00) begin n_fail++; $display("FAIL reset_latency_early e=%0d: got %h want 00", e, sw_out); end
      end else if (e == 6) begin
        n_tests++; if (sw_out !== EXP_ALL || rise !== EXP_ALL || changed !== 1'b1) begin
          n_fail++; $display("FAIL reset_release_update: sw_out %h rise %h changed %b want %h %h 1", sw_out, rise, changed, EXP_ALL, EXP_ALL);
        end
      end else begin
        n_tests++; if (changed !== 1'b0 || rise !== 8'h00 || sw_out !== EXP_ALL) begin
          n_fail++; $display("FAIL reset_pulse_end: sw_out %h rise %h changed %b want %h 00 0", sw_out, rise, changed, EXP_ALL);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b1010;
    settle(8'h00);
    for (int k = 0; k < 4; k++) begin
      sw_in[3] = pat[3-k];
      step();
      n_tests++; if (sw_out !== 8'h00 || stable !== m_stable) begin
        n_fail++; $display("FAIL bounce_toggle k=%0d: sw_out %h stable %b want 00 %b", k, sw_out, stable, m_stable);
      end
    end
    sw_in[3] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_tests++; if (stable !== m_stable) begin n_fail++; $display("FAIL bounce_stable e=%0d: got %b want %b", e, stable, m_stable); end
      if (e < 6) begin
        n_tests++; if (sw_out !== 8'h00) begin n_fail++; $display("FAIL bounce_early e=%0d: got %h want 00", e, sw_out); end
      end else begin
        n_tests++; if (sw_out !== 8'h08 || rise !== 8'h08) begin n_fail++; $display("FAIL bounce_accept: sw_out %h rise %h want 08 08", sw_out, rise); end
      end
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    settle(8'h00);
    sw_in  = 8'h81;
    pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (changed === 1'b1) pulses++;
      if (e == 6) begin
        n_tests++; if (sw_out !== 8'h81 || rise !== 8'h81 || fall !== 8'h00 || changed !== 1'b1) begin
          n_fail++; $display("FAIL simul_update: sw_out %h rise %h fall %h changed %b want 81 81 00 1", sw_out, rise, fall, changed);
        end
      end
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL simul_pulse_count: got %0d want 1", pulses); end
  endtask

  task automatic test_enable();
    int viol;
    settle(8'h00);
    en = 1'b0; sw_in = 8'h10; viol = 0;
    repeat (20) begin
      step();
      if (sw_out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0) viol++;
    end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL enable_freeze: %0d violating cycles want 0", viol); end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL enable_stable: got %b want 1", stable); end
    en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e < 4) begin
        n_tests++; if (sw_out !== 8'h00) begin n_fail++; $display("FAIL enable_restart e=%0d: got %h want 00", e, sw_out); end
      end else begin
        n_tests++; if (sw_out !== 8'h10 || rise !== 8'h10) begin n_fail++; $display("FAIL enable_accept: sw_out %h rise %h want 10 10", sw_out, rise); end
      end
    end
  endtask

  task automatic test_reset_mid();
    settle(8'h00);
    settle(8'h01);
    sw_in = 8'h21;
    repeat (4) step();
    n_tests++; if (stable !== 1'b0 || sw_out !== 8'h01) begin n_fail++; $display("FAIL midrst_pending: stable %b sw_out %h want 0 01", stable, sw_out); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (sw_out !== 8'h00 || stable !== 1'b1 || rise !== 8'h00) begin
      n_fail++; $display("FAIL midrst_immediate: sw_out %h stable %b rise %h want 00 1 00", sw_out, stable, rise);
    end
    step(); step();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e < 6) begin
        n_tests++; if (sw_out !== 8'h00) begin n_fail++; $display("FAIL midrst_early e=%0d: got %h want 00", e, sw_out); end
      end else begin
        n_tests++; if (sw_out !== EXP_21) begin n_fail++; $display("FAIL midrst_accept: got %h want %h", sw_out, EXP_21); end
      end
    end
  endtask

`ifdef SW_DEBOUNCE_LOCK_EN
  task automatic test_lock();
    logic got;
    settle(8'h00);
    settle(8'h01);
    sw_in = 8'h41;
    repeat (20) step();
    n_tests++; if (sw_out !== 8'h01 || stable !== 1'b0) begin n_fail++; $display("FAIL lock_hold: sw_out %h stable %b want 01 0", sw_out, stable); end
    sw_in = 8'h40;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) begin
        n_tests++; if (fall !== 8'h01 || sw_out !== 8'h00) begin n_fail++; $display("FAIL lock_fall: fall %h sw_out %h want 01 00", fall, sw_out); end
      end
    end
    got = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (sw_out === 8'h40) got = 1'b1;
    end
    n_tests++; if (!got || sw_out !== 8'h40) begin n_fail++; $display("FAIL lock_release: sw_out %h want 40", sw_out); end
  endtask
`else
  task automatic test_random();
    settle(8'h00);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) sw_in = sw_in ^ (8'h01 << $urandom_range(7));
      en = ($urandom_range(15) != 0);
      step();
      n_tests++; if (sw_out !== m_out) begin n_fail++; $display("FAIL rand_sw_out c=%0d: got %h want %h", c, sw_out, m_out); end
      n_tests++; if (rise !== m_rise || fall !== m_fall) begin n_fail++; $display("FAIL rand_edges c=%0d: rise %h fall %h want %h %h", c, rise, fall, m_rise, m_fall); end
      n_tests++; if (changed !== m_changed) begin n_fail++; $display("FAIL rand_changed c=%0d: got %b want %b", c, changed, m_changed); end
      n_tests++; if (stable !== m_stable) begin n_fail++; $display("FAIL rand_stable c=%0d: got %b want %b", c, stable, m_stable); end
    end
    en = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b1; sw_in = 8'h00;
    test_reset();
    test_bounce();
`ifndef SW_DEBOUNCE_LOCK_EN
    test_simultaneous();
`endif
    test_enable();
    test_reset_mid();
`ifdef SW_DEBOUNCE_LOCK_EN
    test_lock();
`else
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
